audio_rec_mc: RTL and testbench

AUDIO_REC_MC -- requirements
Module: audio_rec_mc

---
 rtl/audio_rec_mc.sv | 123 ++++++++++++
 tb/tb_audio_rec_mc.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/audio_rec_mc.sv
// I2S ADC capture recorder: deserialises left (or left+right) samples and streams them as SRAM word writes.
// Optional macro AUDIO_REC_WRAP_EN: ring-buffer mode (wrap to address 0 after ADDR_MAX instead of stopping).
module audio_rec_mc #(
  parameter int DATA_W   = 16,
  parameter int CH_NUM   = 1,
  parameter int ADDR_W   = 20,
  parameter int ADDR_MAX = 2**ADDR_W - 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_lrc,
  input  logic              i_adcdat,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  output logic              o_wr,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data,
  output logic [1:0]        o_state,
  output logic [ADDR_W:0]   o_count,
  output logic              o_full
);
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [ADDR_W-1:0] A_MAX = ADDR_W'(ADDR_MAX);
  localparam logic [ADDR_W:0]   C_SAT = (ADDR_W+1)'(ADDR_MAX + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ALIGN = 2'd1, S_REC = 2'd2, S_PAUSE = 2'd3} state_t;

  state_t              r_state;
  logic                r_lrc;
  logic [CW-1:0]       r_cnt;
  logic [DATA_W-2:0]   r_sh;
  logic                r_wr;
  logic                r_full;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic [ADDR_W:0]     r_count;

  logic                w_edge;
  logic                w_left_edge;
  logic                w_last;
  logic                w_ch_ok;
  logic                w_wr;
  logic                w_at_max;
  logic [DATA_W-1:0]   w_word;

  assign w_edge      = i_lrc ^ r_lrc;
  assign w_left_edge = w_edge & ~i_lrc;
  assign w_word      = {r_sh, i_adcdat};
  assign w_last      = ~w_edge && (r_cnt == CW'(DATA_W - 1));
  // r_lrc holds the channel of the half-frame in progress once past its edge
  assign w_ch_ok     = (CH_NUM == 2) || !r_lrc;
  assign w_wr        = w_last && w_ch_ok && (r_state == S_REC) && !i_stop && !i_pause;
  assign w_at_max    = (r_addr == A_MAX);

  // Serial deserialiser: counter restarts on every LR edge, bits past DATA_W are dropped
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lrc <= 1'b0;
      r_cnt <= '0;
      r_sh  <= '0;
    end else begin
      r_lrc <= i_lrc;
      if (w_edge) begin
        r_cnt <= '0;
      end else if (r_cnt != CW'(DATA_W)) begin
        r_cnt <= r_cnt + 1'b1;
        r_sh  <= w_word[DATA_W-2:0];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_wr    <= 1'b0;
      r_full  <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_count <= '0;
    end else begin
      r_wr   <= w_wr;
      r_full <= w_wr && w_at_max;
      if (w_wr) r_data <= w_word;
      // Address/count advance as the write strobe retires
      if (r_wr) begin
`ifdef AUDIO_REC_WRAP_EN
        r_addr <= w_at_max ? '0 : r_addr + 1'b1;
`else
        if (!w_at_max) r_addr <= r_addr + 1'b1;
`endif
        if (r_count != C_SAT) r_count <= r_count + 1'b1;
      end
      if (i_stop) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: if (i_start) begin
            r_state <= S_ALIGN;
            r_addr  <= '0;
            r_count <= '0;
          end
          S_ALIGN: if (w_left_edge) r_state <= S_REC;
          S_REC: begin
            if (i_pause) r_state <= S_PAUSE;
`ifndef AUDIO_REC_WRAP_EN
            else if (w_wr && w_at_max) r_state <= S_IDLE;
`endif
          end
          S_PAUSE: if (i_start) r_state <= S_ALIGN;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_wr    = r_wr;
  assign o_addr  = r_addr;
  assign o_data  = r_data;
  assign o_state = r_state;
  assign o_count = r_count;
  assign o_full  = r_full;
endmodule

// File: tb/tb_audio_rec_mc.sv
// Directed bench for audio_rec_mc: mono, stereo and small-address (full/wrap) instances share one I2S stream.
module tb_audio_rec_mc;
  logic clk = 1'b0;
  logic rst_n, lrc, dat;
  logic [2:0] st, pz, sp;
  int cyc = 0, nerr = 0, nchk = 0, stray_full = 0;

  logic a_wr, a_full, b_wr, b_full, c_wr, c_full;
  logic [19:0] a_addr, b_addr;
  logic [3:0]  c_addr;
  logic [15:0] a_data, b_data, c_data;
  logic [1:0]  a_state, b_state, c_state;
  logic [20:0] a_count, b_count;
  logic [4:0]  c_count;

  typedef struct packed {
    logic [1:0]  id;
    logic [19:0] addr;
    logic [15:0] data;
    logic [31:0] cyc;
    logic        full;
  } wr_t;
  wr_t act_q[$], exp_q[$];

  audio_rec_mc #(.DATA_W(16), .CH_NUM(1), .ADDR_W(20)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_lrc(lrc), .i_adcdat(dat),
    .i_start(st[0]), .i_pause(pz[0]), .i_stop(sp[0]),
    .o_wr(a_wr), .o_addr(a_addr), .o_data(a_data), .o_state(a_state),
    .o_count(a_count), .o_full(a_full));
  audio_rec_mc #(.DATA_W(16), .CH_NUM(2), .ADDR_W(20)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_lrc(lrc), .i_adcdat(dat),
    .i_start(st[1]), .i_pause(pz[1]), .i_stop(sp[1]),
    .o_wr(b_wr), .o_addr(b_addr), .o_data(b_data), .o_state(b_state),
    .o_count(b_count), .o_full(b_full));
  audio_rec_mc #(.DATA_W(16), .CH_NUM(1), .ADDR_W(4), .ADDR_MAX(3)) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_lrc(lrc), .i_adcdat(dat),
    .i_start(st[2]), .i_pause(pz[2]), .i_stop(sp[2]),
    .o_wr(c_wr), .o_addr(c_addr), .o_data(c_data), .o_state(c_state),
    .o_count(c_count), .o_full(c_full));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (a_wr) act_q.push_back({2'd0, a_addr, a_data, cyc, a_full});
    if (b_wr) act_q.push_back({2'd1, b_addr, b_data, cyc, b_full});
    if (c_wr) act_q.push_back({2'd2, 16'd0, c_addr, c_data, cyc, c_full});
    if ((a_full && !a_wr) || (b_full && !b_wr) || (c_full && !c_wr)) stray_full++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expw(input logic [1:0] id, input logic [19:0] addr, input logic [15:0] d,
                      input int c, input logic f);
    exp_q.push_back({id, addr, d, c, f});
  endtask

  // One 20-cycle half-frame: LR edge cycle, 16 data bits MSB first, 3 pad bits.
  // Command pulses land on the cycle carrying data bit index cbit (0 = MSB).
  task automatic half(input logic l, input logic [15:0] w, input int cbit,
                      input logic [2:0] cst, input logic [2:0] cpz, input logic [2:0] csp,
                      output int lsb);
    @(negedge clk);
    lrc = l; dat = 1'b0;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      dat = (i < 16) ? w[15-i] : 1'b0;
      st  = (i == cbit) ? cst : 3'b000;
      pz  = (i == cbit) ? cpz : 3'b000;
      sp  = (i == cbit) ? csp : 3'b000;
      if (i == 15) lsb = cyc + 1;
    end
  endtask

  initial begin
    int l;
    logic [15:0] cw [5];
    logic [15:0] part;
    cw[0] = 16'h1111; cw[1] = 16'h2222; cw[2] = 16'h3333; cw[3] = 16'h4444; cw[4] = 16'h5555;
    rst_n = 1'b0; lrc = 1'b1; dat = 1'b0; st = '0; pz = '0; sp = '0;
    repeat (3) @(negedge clk);
    chk("rst_wr", a_wr, 0);       chk("rst_addr", a_addr, 0);   chk("rst_data", a_data, 0);
    chk("rst_state", a_state, 0); chk("rst_count", a_count, 0); chk("rst_full", a_full, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // mono capture of three left words
    st = 3'b001; @(negedge clk); st = '0;
    chk("a_align", a_state, 1);
    half(1'b0, 16'h0123, -1, 0, 0, 0, l); expw(0, 0, 16'h0123, l, 0);
    chk("a_rec", a_state, 2);
    half(1'b1, 16'hFFFF, -1, 0, 0, 0, l);
    half(1'b0, 16'h1234, -1, 0, 0, 0, l); expw(0, 1, 16'h1234, l, 0);
    half(1'b1, 16'hF0F0, -1, 0, 0, 0, l);
    half(1'b0, 16'h2345, -1, 0, 0, 0, l); expw(0, 2, 16'h2345, l, 0);
    half(1'b1, 16'hFFFF, -1, 0, 0, 0, l);
    chk("a_count3", a_count, 3); chk("a_addr3", a_addr, 3);

    // pause mid-word, idle frame, resume, next left word lands at addr 3
    half(1'b0, 16'h3456, 5, 0, 3'b001, 0, l);
    chk("a_paused", a_state, 3);
    half(1'b1, 16'hFFFF, -1, 0, 0, 0, l);
    half(1'b0, 16'h5555, -1, 0, 0, 0, l);
    half(1'b1, 16'h0F0F, 2, 3'b001, 0, 0, l);
    chk("a_resume_align", a_state, 1); chk("a_count_held", a_count, 3);
    half(1'b0, 16'h4567, -1, 0, 0, 0, l); expw(0, 3, 16'h4567, l, 0);
    chk("a_rec2", a_state, 2);

    // stop A and start stereo B in the same right half-frame
    half(1'b1, 16'hFFFF, 3, 3'b010, 0, 3'b001, l);
    chk("a_stopped", a_state, 0); chk("a_addr4", a_addr, 4); chk("a_count4", a_count, 4);
    chk("b_align", b_state, 1);
    half(1'b0, 16'hABCD, -1, 0, 0, 0, l); expw(1, 0, 16'hABCD, l, 0);
    half(1'b1, 16'h1234, -1, 0, 0, 0, l); expw(1, 1, 16'h1234, l, 0);
    // stop beats pause
    half(1'b0, 16'h9999, 4, 0, 3'b010, 3'b010, l);
    chk("b_stop_wins", b_state, 0); chk("b_count2", b_count, 2); chk("b_addr2", b_addr, 2);

    // small address space: full pulse on addr 3, then stop or wrap
    half(1'b1, 16'hFFFF, 2, 3'b100, 0, 0, l);
    chk("c_align", c_state, 1);
    for (int k = 0; k < 5; k++) begin
      half(1'b0, cw[k], -1, 0, 0, 0, l);
`ifdef AUDIO_REC_WRAP_EN
      expw(2, 20'(k % 4), cw[k], l, k == 3);
`else
      if (k < 4) expw(2, 20'(k), cw[k], l, k == 3);
`endif
      half(1'b1, 16'hFFFF, -1, 0, 0, 0, l);
    end
`ifdef AUDIO_REC_WRAP_EN
    chk("c_state_wrap", c_state, 2); chk("c_addr_wrap", c_addr, 1);
`else
    chk("c_state_full", c_state, 0); chk("c_addr_full", c_addr, 3);
`endif
    chk("c_count_sat", c_count, 4);
    half(1'b0, 16'h6666, 2, 0, 0, 3'b100, l);
    chk("c_stopped", c_state, 0); chk("c_count_held", c_count, 4);

    // restart A clears address, then reset mid-word
    half(1'b1, 16'hFFFF, 2, 3'b001, 0, 0, l);
    chk("a_restart_addr", a_addr, 0); chk("a_restart_count", a_count, 0);
    half(1'b0, 16'h7777, -1, 0, 0, 0, l); expw(0, 0, 16'h7777, l, 0);
    half(1'b1, 16'hFFFF, -1, 0, 0, 0, l);
    chk("a_count1", a_count, 1); chk("a_addr1", a_addr, 1);
    @(negedge clk); lrc = 1'b0; dat = 1'b0;
    part = 16'h8888;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); dat = part[15-i];
    end
    rst_n = 1'b0;
    #1;
    chk("mid_wr", a_wr, 0);       chk("mid_addr", a_addr, 0);   chk("mid_data", a_data, 0);
    chk("mid_state", a_state, 0); chk("mid_count", a_count, 0); chk("mid_full", a_full, 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    half(1'b1, 16'hFFFF, -1, 0, 0, 0, l);
    half(1'b0, 16'hAAAA, -1, 0, 0, 0, l);
    half(1'b1, 16'hFFFF, -1, 0, 0, 0, l);
    chk("post_rst_idle", a_state, 0); chk("post_rst_count", a_count, 0);

    chk("wr_total", act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < act_q.size()) begin
        chk($sformatf("wr%0d_id_addr", i), {10'd0, act_q[i].id, act_q[i].addr}, {10'd0, exp_q[i].id, exp_q[i].addr});
        chk($sformatf("wr%0d_data", i), act_q[i].data, exp_q[i].data);
        chk($sformatf("wr%0d_cycle", i), act_q[i].cyc, exp_q[i].cyc);
        chk($sformatf("wr%0d_full", i), act_q[i].full, exp_q[i].full);
      end
    end
    chk("stray_full", stray_full, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
